// File: rtl/cpu_ext_pkg.sv
// Shared types for the ID-stage immediate extender: extension op codes and
// the queue entry layout {err, imm}.
package cpu_ext_pkg;

    typedef enum logic [2:0] {
        EXTOP_ZERO   = 3'd0,
        EXTOP_SIGN   = 3'd1,
        EXTOP_LUI    = 3'd2,
        EXTOP_SHAMT  = 3'd3,
        EXTOP_BRANCH = 3'd4,
        EXTOP_JUMP   = 3'd5
    } ext_op_t;

    localparam int EXT_XLEN    = 32;
    localparam int EXT_ENTRY_W = EXT_XLEN + 1;

    typedef struct packed {
        logic                err;
        logic [EXT_XLEN-1:0] imm;
    } ext_entry_t;

endpackage

// File: rtl/imm_ext_calc.sv
// Combinational immediate / branch-target / jump-target generator.
// Op codes 6-7 yield a zero value with the error flag set.
module imm_ext_calc
    import cpu_ext_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int IMM_W = 16
) (
    input  logic [2:0]       i_op,
    input  logic [IMM_W-1:0] i_imm,
    input  logic [XLEN-1:0]  i_pc,
    input  logic [25:0]      i_index,
    output logic [XLEN-1:0]  o_imm,
    output logic             o_err
);

    logic [XLEN-1:0] w_pc4;
    logic [XLEN-1:0] w_sext;

    assign w_pc4  = i_pc + XLEN'(4);
    assign w_sext = {{(XLEN-IMM_W){i_imm[IMM_W-1]}}, i_imm};

    always_comb begin
        o_imm = '0;
        o_err = 1'b0;
        case (i_op)
            EXTOP_ZERO:   o_imm = {{(XLEN-IMM_W){1'b0}}, i_imm};
            EXTOP_SIGN:   o_imm = w_sext;
            EXTOP_LUI:    o_imm = {i_imm, {(XLEN-IMM_W){1'b0}}};
            EXTOP_SHAMT:  o_imm = {{(XLEN-5){1'b0}}, i_imm[10:6]};
            EXTOP_BRANCH: o_imm = w_pc4 + (w_sext << 2);
            EXTOP_JUMP:   o_imm = {w_pc4[XLEN-1:28], i_index, 2'b00};
            default:      o_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Buffered immediate generator: computes the value at push time and queues it
// in a DEPTH-entry FIFO. Define IMM_EXT_BYPASS_EN for a 0-cycle empty-queue bypass.
module imm_ext_pipe
    import cpu_ext_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int IMM_W = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [IMM_W-1:0] in_imm,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [25:0]      in_index,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_err
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = XLEN + (EXT_ENTRY_W - EXT_XLEN);

    logic [XLEN-1:0]    w_calc_imm;
    logic               w_calc_err;
    logic [ENTRY_W-1:0] w_head;
    logic               w_not_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_bypass_take;

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    imm_ext_calc #(
        .XLEN  (XLEN),
        .IMM_W (IMM_W)
    ) u_calc (
        .i_op    (in_op),
        .i_imm   (in_imm),
        .i_pc    (in_pc),
        .i_index (in_index),
        .o_imm   (w_calc_imm),
        .o_err   (w_calc_err)
    );

    assign w_not_empty = (r_count != '0);
    assign w_head      = r_mem[r_rd_ptr];
    assign in_ready    = (r_count < CNT_W'(DEPTH)) || out_ready;

`ifdef IMM_EXT_BYPASS_EN
    logic w_bypass;
    // An empty queue forwards the freshly computed value straight to the output.
    assign w_bypass      = !w_not_empty && in_valid && !flush;
    assign w_bypass_take = w_bypass && out_ready;
    assign out_valid     = w_not_empty || w_bypass;
    assign out_imm       = w_not_empty ? w_head[XLEN-1:0] : (w_bypass ? w_calc_imm : '0);
    assign out_err       = w_not_empty ? w_head[XLEN]     : (w_bypass && w_calc_err);
`else
    assign w_bypass_take = 1'b0;
    assign out_valid     = w_not_empty;
    assign out_imm       = w_not_empty ? w_head[XLEN-1:0] : '0;
    assign out_err       = w_not_empty && w_head[XLEN];
`endif

    assign w_push = in_valid && in_ready && !flush && !w_bypass_take;
    assign w_pop  = w_not_empty && out_ready && !flush;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Storage carries no reset; the count masks stale contents from the output.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_calc_err, w_calc_imm};
        end
    end

endmodule
